// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the uart_tx arbiter slice.
package uart_tx_arbiter_pkg;

  localparam int unsigned UartDataW = 8;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StLoad     = 3'd1,
    StStart    = 3'd2,
    StWaitBusy = 3'd3,
    StWaitDone = 3'd4
  } arb_state_e;

  // Increment an index modulo n; n need not be a power of two.
  function automatic int unsigned rr_wrap_inc(int unsigned idx, int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module uart_tx_arbiter_rr #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         winner,
  output logic [$clog2(NUM_REQ)-1:0] winner_idx,
  output logic                       any_req
);

  localparam int unsigned PtrW = $clog2(NUM_REQ);

  always_comb begin
    int unsigned j;
    logic        found;
    j          = 0;
    found      = 1'b0;
    winner     = '0;
    winner_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      j = 32'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req[j]) begin
        found      = 1'b1;
        winner[j]  = 1'b1;
        winner_idx = PtrW'(j);
      end
    end
    any_req = |req;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between NUM_REQ byte-stream clients, round-robin, with
// message locking and transmitter liveness checking.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned LOCK_TIMEOUT = 4096,
  parameter int unsigned BUSY_TIMEOUT = 64
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_last,
  input  logic [UartDataW*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             grant,
  output logic                           tx_start,
  output logic [UartDataW-1:0]           tx_data,
  input  logic                           tx_busy,
  output logic                           fault
);

  localparam int unsigned PtrW  = $clog2(NUM_REQ);
  localparam int unsigned LockW = $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned BusyW = $clog2(BUSY_TIMEOUT + 1);

  arb_state_e           state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [PtrW-1:0]      win_q, win_d;
  logic [PtrW-1:0]      ptr_q, ptr_d;
  logic [UartDataW-1:0] tx_data_q, tx_data_d;
  logic                 last_q, last_d;
  logic                 fault_q, fault_d;
  logic [LockW-1:0]     lock_cnt_q, lock_cnt_d;
  logic [BusyW-1:0]     busy_cnt_q, busy_cnt_d;

  logic [NUM_REQ-1:0]   arb_winner;
  logic [PtrW-1:0]      arb_idx;
  logic                 arb_any;

  uart_tx_arbiter_rr #(
    .NUM_REQ(NUM_REQ)
  ) u_rr (
    .req        (req_valid),
    .ptr        (ptr_q),
    .winner     (arb_winner),
    .winner_idx (arb_idx),
    .any_req    (arb_any)
  );

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    win_d      = win_q;
    ptr_d      = ptr_q;
    tx_data_d  = tx_data_q;
    last_d     = last_q;
    fault_d    = fault_q;
    lock_cnt_d = lock_cnt_q;
    busy_cnt_d = busy_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (arb_any && !tx_busy) begin
          grant_d = arb_winner;
          win_d   = arb_idx;
          state_d = StLoad;
        end
      end
      StLoad: begin
        // Byte is taken regardless of valid here; dropping valid in LOAD is a client error.
        tx_data_d = req_data[UartDataW*32'(win_q) +: UartDataW];
        last_d    = req_last[win_q];
        state_d   = StStart;
      end
      StStart: begin
        busy_cnt_d = '0;
        state_d    = StWaitBusy;
      end
      StWaitBusy: begin
        if (tx_busy) begin
          lock_cnt_d = '0;
          state_d    = StWaitDone;
        end else if (busy_cnt_q == BusyW'(BUSY_TIMEOUT - 1)) begin
          fault_d = 1'b1;
          grant_d = '0;
          state_d = StIdle;
        end else begin
          busy_cnt_d = busy_cnt_q + BusyW'(1);
        end
      end
      StWaitDone: begin
        if (!tx_busy) begin
          if (last_q) begin
            grant_d = '0;
            ptr_d   = PtrW'(rr_wrap_inc(32'(win_q), NUM_REQ));
            state_d = StIdle;
          end else if (req_valid[win_q]) begin
            state_d = StLoad;
          end else if (lock_cnt_q == LockW'(LOCK_TIMEOUT - 1)) begin
            // Stalled lock: release without flagging a fault.
            grant_d = '0;
            ptr_d   = PtrW'(rr_wrap_inc(32'(win_q), NUM_REQ));
            state_d = StIdle;
          end else begin
            lock_cnt_d = lock_cnt_q + LockW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      win_q      <= '0;
      ptr_q      <= '0;
      tx_data_q  <= '0;
      last_q     <= 1'b0;
      fault_q    <= 1'b0;
      lock_cnt_q <= '0;
      busy_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      win_q      <= win_d;
      ptr_q      <= ptr_d;
      tx_data_q  <= tx_data_d;
      last_q     <= last_d;
      fault_q    <= fault_d;
      lock_cnt_q <= lock_cnt_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign req_ready = (state_q == StLoad) ? grant_q : '0;
  assign tx_start  = (state_q == StStart);
  assign grant     = grant_q;
  assign tx_data   = tx_data_q;
  assign fault     = fault_q;

endmodule
